// File: rtl/fpu_decode_stage.sv
// fpu_decode_stage: registered decode stage between fetch and the FP execute units.
// Splits {RL,RR,RD,OP} into fields. A per-register busy scoreboard stalls RAW/WAW
// hazards until writeback clears the destination. Writeback bypasses in the same
// cycle, so a clearing register never costs an extra stall cycle.
module fpu_decode_stage #(
  parameter int REG_W       = 5,
  parameter int OP_W        = 2,
  parameter int ZERO_REG_EN = 0,
  parameter int CNT_W       = 16,
  localparam int NUM_REGS   = 2**REG_W,
  localparam int ISIZE      = 3*REG_W + OP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ISIZE-1:0]    in_inst,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [REG_W-1:0]    out_rl,
  output logic [REG_W-1:0]    out_rr,
  output logic [REG_W-1:0]    out_rd,
  output logic [OP_W-1:0]     out_op,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic                r_out_valid;
  logic [REG_W-1:0]    r_rl;
  logic [REG_W-1:0]    r_rr;
  logic [REG_W-1:0]    r_rd;
  logic [OP_W-1:0]     r_op;
  logic [NUM_REGS-1:0] r_busy;
  logic [CNT_W-1:0]    r_stall;

  logic [REG_W-1:0]    w_rl;
  logic [REG_W-1:0]    w_rr;
  logic [REG_W-1:0]    w_rd;
  logic [OP_W-1:0]     w_op;
  logic [NUM_REGS-1:0] w_eff;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_hazard;
  logic                w_slot_free;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_stall_evt;

  assign w_rl = in_inst[ISIZE-1 -: REG_W];
  assign w_rr = in_inst[ISIZE-1-REG_W -: REG_W];
  assign w_rd = in_inst[ISIZE-1-2*REG_W -: REG_W];
  assign w_op = in_inst[OP_W-1:0];

  // Effective busy view: a register being written back this cycle is already free.
  always_comb begin
    w_eff = r_busy;
    if (wb_valid) begin
      w_eff[wb_rd] = 1'b0;
    end
    if (ZERO_REG_EN != 0) begin
      w_eff[0] = 1'b0;
    end
  end

  assign w_hazard    = in_valid & (w_eff[w_rl] | w_eff[w_rr] | w_eff[w_rd]);
  assign w_slot_free = ~r_out_valid | out_ready;
  assign w_in_ready  = w_slot_free & ~w_hazard;
  assign w_accept    = in_valid & w_in_ready;
  // Backpressure-only cycles are not hazard stalls, hence the slot_free term.
  assign w_stall_evt = w_hazard & w_slot_free;

  // Scoreboard update: clear on writeback first, then the accepted destination wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid) begin
      w_busy_nxt[wb_rd] = 1'b0;
    end
    if (w_accept) begin
      w_busy_nxt[w_rd] = 1'b1;
    end
    if (ZERO_REG_EN != 0) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  // Output register, scoreboard and saturating stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_rl        <= '0;
      r_rr        <= '0;
      r_rd        <= '0;
      r_op        <= '0;
      r_busy      <= '0;
      r_stall     <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_stall_evt && (r_stall != {CNT_W{1'b1}})) begin
        r_stall <= r_stall + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_rl        <= w_rl;
        r_rr        <= w_rr;
        r_rd        <= w_rd;
        r_op        <= w_op;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_rl    = r_rl;
  assign out_rr    = r_rr;
  assign out_rd    = r_rd;
  assign out_op    = r_op;
  assign busy_vec  = r_busy;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_fpu_decode_stage.sv
// Bench for fpu_decode_stage: directed vectors, scoreboard queue of expected
// instructions popped by an independent output monitor.
module tb_fpu_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, wb_valid;
  logic [16:0] in_inst;
  logic [4:0]  wb_rd;
  logic        in_ready, out_valid;
  logic [4:0]  out_rl, out_rr, out_rd;
  logic [1:0]  out_op;
  logic [31:0] busy_vec;
  logic [15:0] stall_cnt;

  logic        z_in_valid, z_out_ready, z_wb_valid;
  logic [16:0] z_in_inst;
  logic [4:0]  z_wb_rd;
  logic        z_in_ready, z_out_valid;
  logic [4:0]  z_out_rl, z_out_rr, z_out_rd;
  logic [1:0]  z_out_op;
  logic [31:0] z_busy;
  logic [15:0] z_stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  fpu_decode_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rl(out_rl), .out_rr(out_rr), .out_rd(out_rd), .out_op(out_op),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .busy_vec(busy_vec), .stall_cnt(stall_cnt)
  );

  fpu_decode_stage #(.ZERO_REG_EN(1)) dut_z (
    .clk(clk), .rst(rst),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_inst(z_in_inst),
    .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_rl(z_out_rl), .out_rr(z_out_rr), .out_rd(z_out_rd), .out_op(z_out_op),
    .wb_valid(z_wb_valid), .wb_rd(z_wb_rd),
    .busy_vec(z_busy), .stall_cnt(z_stall_cnt)
  );

  function automatic logic [16:0] mk(input int rl, input int rr, input int rd, input int op);
    return {rl[4:0], rr[4:0], rd[4:0], op[1:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every transfer on the output side must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual rd=%0d required none", out_rd);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        chk("sb_rl", 32'(out_rl), 32'(e[16:12]));
        chk("sb_rr", 32'(out_rr), 32'(e[11:7]));
        chk("sb_rd", 32'(out_rd), 32'(e[6:2]));
        chk("sb_op", 32'(out_op), 32'(e[1:0]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test1();
    in_inst = mk(12, 11, 10, 2);
    in_valid = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(in_inst);
    @(negedge clk);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_busy", busy_vec, 32'h0000_0400);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; wb_valid = 1'b0; in_inst = '0; wb_rd = '0;
    z_in_valid = 1'b0; z_out_ready = 1'b1; z_wb_valid = 1'b0; z_in_inst = '0; z_wb_rd = '0;
    cyc();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_fields", 32'({out_rl, out_rr, out_rd, out_op}), 32'd0);
    rst = 1'b0;
    cyc();

    // Register 0 exempt: back-to-back RD=0/RL=0 both accepted.
    z_in_valid = 1'b1;
    z_in_inst = mk(0, 3, 0, 0);
    @(negedge clk);
    chk("z_first_ready", 32'(z_in_ready), 32'd1);
    cyc();
    z_in_inst = mk(0, 4, 0, 1);
    @(negedge clk);
    chk("z_second_ready", 32'(z_in_ready), 32'd1);
    cyc();
    z_in_valid = 1'b0;
    chk("z_out_valid", 32'(z_out_valid), 32'd1);
    chk("z_out_fields", 32'({z_out_rl, z_out_rr, z_out_rd, z_out_op}), 32'(mk(0, 4, 0, 1)));
    chk("z_busy", z_busy, 32'd0);
    chk("z_stall", 32'(z_stall_cnt), 32'd0);

    test1();

    // RAW stall on RL=10, then same-cycle writeback bypass.
    in_inst = mk(10, 1, 2, 0);
    in_valid = 1'b1;
    exp_q.push_back(in_inst);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_in_ready_stall", 32'(in_ready), 32'd0);
      cyc();
      chk("t2_stall_cnt", 32'(stall_cnt), 32'(i + 1));
    end
    wb_valid = 1'b1;
    wb_rd = 5'd10;
    @(negedge clk);
    chk("t2_bypass_ready", 32'(in_ready), 32'd1);
    cyc();
    wb_valid = 1'b0;
    in_valid = 1'b0;
    chk("t2_stall_final", 32'(stall_cnt), 32'd3);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_busy", busy_vec, 32'h0000_0004);

    // Backpressure: outputs hold, nothing accepted, stall counter untouched.
    out_ready = 1'b0;
    in_inst = mk(3, 4, 5, 1);
    in_valid = 1'b1;
    exp_q.push_back(in_inst);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_in_ready_bp", 32'(in_ready), 32'd0);
      chk("t3_hold", 32'({out_valid, out_rl, out_rr, out_rd, out_op}), 32'({1'b1, mk(10, 1, 2, 0)}));
      cyc();
    end
    chk("t3_stall_same", 32'(stall_cnt), 32'd3);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    chk("t3_next_valid", 32'(out_valid), 32'd1);
    chk("t3_next_rd", 32'(out_rd), 32'd5);

    // Same-cycle clear and set of register 5: set wins.
    in_inst = mk(6, 7, 5, 3);
    in_valid = 1'b1;
    wb_valid = 1'b1;
    wb_rd = 5'd5;
    exp_q.push_back(in_inst);
    @(negedge clk);
    chk("t4_in_ready", 32'(in_ready), 32'd1);
    cyc();
    wb_valid = 1'b0;
    chk("t4_busy", busy_vec, 32'h0000_0024);

    // Full throughput, plus writeback to a non-busy register.
    in_inst = mk(1, 1, 8, 0);
    exp_q.push_back(in_inst);
    @(negedge clk);
    chk("tp_ready_a", 32'(in_ready), 32'd1);
    cyc();
    in_inst = mk(9, 9, 12, 1);
    exp_q.push_back(in_inst);
    wb_valid = 1'b1;
    wb_rd = 5'd20;
    @(negedge clk);
    chk("tp_ready_b", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    wb_valid = 1'b0;
    chk("tp_busy", busy_vec, 32'h0000_1124);
    chk("tp_out_rd", 32'(out_rd), 32'd12);

    // Asynchronous reset mid-cycle with a held output and busy registers.
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_busy", busy_vec, 32'd0);
    chk("ar_stall", 32'(stall_cnt), 32'd0);
    chk("ar_fields", 32'({out_rl, out_rr, out_rd, out_op}), 32'd0);
    exp_q.delete();
    cyc();
    rst = 1'b0;
    cyc();
    chk("ar_no_reappear", 32'(out_valid), 32'd0);

    test1();
    chk("t1r_stall", 32'(stall_cnt), 32'd0);

    // Without the register-0 exemption the second RD=0 instruction stalls.
    in_inst = mk(0, 3, 0, 0);
    in_valid = 1'b1;
    exp_q.push_back(in_inst);
    @(negedge clk);
    chk("zr0_first_ready", 32'(in_ready), 32'd1);
    cyc();
    in_inst = mk(0, 4, 0, 1);
    exp_q.push_back(in_inst);
    @(negedge clk);
    chk("zr0_second_stall", 32'(in_ready), 32'd0);
    cyc();
    wb_valid = 1'b1;
    wb_rd = 5'd0;
    @(negedge clk);
    chk("zr0_bypass_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    wb_valid = 1'b0;
    chk("zr0_busy", busy_vec, 32'h0000_0401);
    chk("zr0_stall", 32'(stall_cnt), 32'd1);

    // Saturation: hold a hazard long enough to reach all-ones.
    in_inst = mk(10, 0, 0, 0);
    in_valid = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_stall", 32'(stall_cnt), 32'h0000_FFFF);
    chk("sat_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    repeat (3) cyc();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
